// File: rtl/spi_master_if.sv
// Byte stream and SPI pin bundle for spi_master.
// master: the SPI block side; slave: the host / pad side.
interface spi_master_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cs_n;
  logic       sck;
  logic       mosi;
  logic       miso;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid,
    output cs_n, sck, mosi
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid,
    input  cs_n, sck, mosi
  );
endinterface

// File: rtl/spi_master.sv
// Length-prefixed SPI mode-0 master, MSB first.
// Define SPI_MASTER_RX_EN to enable the MISO receive path.
module spi_master #(
  parameter int unsigned CLK_DIV = 1
) (
  input logic         clk,
  input logic         rst_n,
  spi_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    CS_HOLD
  } state_t;

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] count;
  logic [7:0] div;
  logic [6:0] tx_sh;
  logic [2:0] bit_idx;
  logic       cs_n_q;
  logic       sck_q;
  logic       mosi_q;

  logic half_done;
  logic take;
  logic sample;

  assign half_done = div == LAST;
  assign bus.tx_ready = (state == IDLE) ||
                        (state == WAIT_BYTE);
  assign take = bus.tx_valid && bus.tx_ready;
  assign sample = (state == SHIFT) && half_done &&
                  !sck_q;

  assign bus.cs_n = cs_n_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= 8'd0;
      div     <= 8'd0;
      tx_sh   <= 7'd0;
      bit_idx <= 3'd0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take && bus.tx_data != 8'd0) begin
            count <= bus.tx_data;
            state <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          if (take) begin
            mosi_q  <= bus.tx_data[7];
            tx_sh   <= bus.tx_data[6:0];
            count   <= count - 8'd1;
            cs_n_q  <= 1'b0;
            div     <= 8'd0;
            bit_idx <= 3'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!half_done) begin
            div <= div + 8'd1;
          end else begin
            div <= 8'd0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              // mosi only moves on the falling edge
              if (bit_idx == 3'd7) begin
                state <= (count != 8'd0) ?
                         WAIT_BYTE : CS_HOLD;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                mosi_q  <= tx_sh[6];
                tx_sh   <= {tx_sh[5:0], 1'b0};
              end
            end
          end
        end
        CS_HOLD: begin
          if (!half_done) begin
            div <= div + 8'd1;
          end else begin
            div    <= 8'd0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [7:0] rx_sh;
  logic [7:0] rx_data_q;
  logic       rx_done;
  logic       rx_valid_q;

  // Completed byte is published one edge after bit 0 lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh      <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_done    <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_done;
      rx_done    <= 1'b0;
      if (rx_done) begin
        rx_data_q <= rx_sh;
      end
      if (sample) begin
        rx_sh   <= {rx_sh[6:0], bus.miso};
        rx_done <= bit_idx == 3'd7;
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`else
  logic unused_rx;
  assign unused_rx = bus.miso ^ sample;
  assign bus.rx_data  = 8'h00;
  assign bus.rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master, CLK_DIV=1 and CLK_DIV=4 instances.
// Waveform model built from per-byte elapsed time.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if if1 ();
  spi_master_if if4 ();

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1.master)
  );

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if4.master)
  );

  int checks = 0;
  int errors = 0;

  int rise1 = 0, cslow1 = 0, rxv1 = 0;
  int rise4 = 0, cslow4 = 0, hi4 = 0;
  logic [15:0] mos1 = '0;
  logic [7:0]  mos4 = '0;
  logic p_sck1 = 1'b0, p_sck4 = 1'b0;
  logic [7:0] miso_pat = 8'h00;

  // slave presents bit (7 - rises so far) of the pattern
  assign if1.miso = miso_pat[~rise1[2:0]];
  assign if4.miso = 1'b0;

  // model: mode 0 idle, 1 wait, 2 shift, 3 cs hold
  int dv [2] = '{1, 4};
  int m_mode [2] = '{0, 0};
  int m_rem [2] = '{0, 0};
  int m_t [2] = '{0, 0};
  int m_h [2] = '{0, 0};
  logic [7:0] m_byte [2] = '{8'h0, 8'h0};
  logic [7:0] m_rxsh [2] = '{8'h0, 8'h0};
  logic [7:0] m_rxd [2] = '{8'h0, 8'h0};
  logic m_intxn [2] = '{1'b0, 1'b0};
  logic m_pend [2] = '{1'b0, 1'b0};
  logic m_rxv [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    logic v;
    logic [7:0] d;
    logic mi;
    int dd;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_mode[i] = 0;
        m_rem[i] = 0;
        m_t[i] = 0;
        m_h[i] = 0;
        m_byte[i] = 8'h0;
        m_rxsh[i] = 8'h0;
        m_rxd[i] = 8'h0;
        m_intxn[i] = 1'b0;
        m_pend[i] = 1'b0;
        m_rxv[i] = 1'b0;
      end else begin
        v  = (i == 0) ? if1.tx_valid : if4.tx_valid;
        d  = (i == 0) ? if1.tx_data : if4.tx_data;
        mi = (i == 0) ? if1.miso : if4.miso;
        dd = dv[i];
        m_rxv[i] = m_pend[i];
        if (m_pend[i]) m_rxd[i] = m_rxsh[i];
        m_pend[i] = 1'b0;
        case (m_mode[i])
          0: if (v && d != 8'd0) begin
            m_rem[i] = int'(d);
            m_mode[i] = 1;
            m_intxn[i] = 1'b0;
          end
          1: if (v) begin
            m_byte[i] = d;
            m_rem[i] = m_rem[i] - 1;
            m_mode[i] = 2;
            m_t[i] = 0;
            m_intxn[i] = 1'b1;
          end
          2: begin
            if ((m_t[i] + 1) % (2 * dd) == dd) begin
              m_rxsh[i] = {m_rxsh[i][6:0], mi};
              if ((m_t[i] + 1) / (2 * dd) == 7)
                m_pend[i] = 1'b1;
            end
            m_t[i] = m_t[i] + 1;
            if (m_t[i] == 16 * dd) begin
              m_mode[i] = (m_rem[i] != 0) ? 1 : 3;
              m_h[i] = 0;
            end
          end
          default: begin
            m_h[i] = m_h[i] + 1;
            if (m_h[i] == dd) begin
              m_mode[i] = 0;
              m_intxn[i] = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // {tx_ready, cs_n, sck, mosi, rx_valid, rx_data}
  function automatic logic [12:0] expv(int i);
    int dd;
    logic rdy, cs, sck, mosi, rxv;
    logic [7:0] rxd;
    dd = dv[i];
    rdy = m_mode[i] <= 1;
    sck = (m_mode[i] == 2) &&
          ((m_t[i] % (2 * dd)) >= dd);
    if (m_mode[i] == 2)
      mosi = m_byte[i][7 - m_t[i] / (2 * dd)];
    else
      mosi = m_intxn[i] ? m_byte[i][0] : 1'b0;
    cs = !(m_mode[i] >= 2 ||
           (m_mode[i] == 1 && m_intxn[i]));
`ifdef SPI_MASTER_RX_EN
    rxv = m_rxv[i];
    rxd = m_rxd[i];
`else
    rxv = 1'b0;
    rxd = 8'h00;
`endif
    return {rdy, cs, sck, mosi, rxv, rxd};
  endfunction

  task automatic tick();
    logic [12:0] act;
    logic [12:0] e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0)
        act = {if1.tx_ready, if1.cs_n, if1.sck,
               if1.mosi, if1.rx_valid, if1.rx_data};
      else
        act = {if4.tx_ready, if4.cs_n, if4.sck,
               if4.mosi, if4.rx_valid, if4.rx_data};
      e = expv(i);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle div%0d t=%0t rdy/cs/sck/mosi/rxv/rxd got %b need %b",
                 dv[i], $time, act, e);
      end
    end
    if (if1.sck && !p_sck1) begin
      rise1++;
      mos1 = {mos1[14:0], if1.mosi};
    end
    p_sck1 = if1.sck;
    if (!if1.cs_n) cslow1++;
    if (if1.rx_valid) rxv1++;
    if (if4.sck && !p_sck4) begin
      rise4++;
      mos4 = {mos4[6:0], if4.mosi};
    end
    p_sck4 = if4.sck;
    if (if4.sck) hi4++;
    if (!if4.cs_n) cslow4++;
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) need %0d (0x%0h)",
               name, act, act, req, req);
    end
  endtask

  task automatic send(int s, logic [7:0] b);
    int n;
    logic rdy;
    n = 0;
    if (s == 0) begin
      if1.tx_data = b;
      if1.tx_valid = 1'b1;
    end else begin
      if4.tx_data = b;
      if4.tx_valid = 1'b1;
    end
    do begin
      rdy = (s == 0) ? if1.tx_ready : if4.tx_ready;
      tick();
      n++;
    end while (!rdy && n < 3000);
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout got no tx_ready need accept of %h", b);
    end
  endtask

  task automatic drop(int s);
    if (s == 0) if1.tx_valid = 1'b0;
    else if4.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(int s);
    int n;
    n = 0;
    while (((s == 0) ? if1.cs_n : if4.cs_n) !== 1'b1 &&
           n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL idle_timeout got cs_n low need cs_n high");
    end
  endtask

  initial begin
    int r0, c0, v0, h0, bad, n;
    if1.tx_valid = 1'b0;
    if1.tx_data = 8'h00;
    if4.tx_valid = 1'b0;
    if4.tx_data = 8'h00;
    repeat (3) tick();
    chk("rst_cs_n", int'(if1.cs_n), 1);
    chk("rst_sck", int'(if1.sck), 0);
    chk("rst_tx_ready", int'(if1.tx_ready), 1);
    chk("rst_rx_valid", int'(if1.rx_valid), 0);
    chk("rst_rx_data", int'(if1.rx_data), 0);
    rst_n = 1'b1;
    tick();

    // two back-to-back payload bytes
    r0 = rise1;
    c0 = cslow1;
    send(0, 8'd2);
    send(0, 8'h5F);
    send(0, 8'h10);
    drop(0);
    wait_idle(0);
    tick();
    chk("t032_rises", rise1 - r0, 16);
    chk("t032_mosi", int'(mos1), 'h5F10);
    chk("t032_cs_low", cslow1 - c0, 34);

    // receive 8'hC3
    miso_pat = 8'hC3;
    v0 = rxv1;
    send(0, 8'd1);
    send(0, 8'h3C);
    drop(0);
    wait_idle(0);
    repeat (2) tick();
    chk("t034_mosi", int'(mos1[7:0]), 'h3C);
`ifdef SPI_MASTER_RX_EN
    chk("t034_rx_pulses", rxv1 - v0, 1);
    chk("t034_rx_data", int'(if1.rx_data), 'hC3);
`else
    chk("t034_rx_pulses", rxv1 - v0, 0);
    chk("t034_rx_data", int'(if1.rx_data), 0);
`endif

    // divide-by-4 single byte
    r0 = rise4;
    c0 = cslow4;
    h0 = hi4;
    send(1, 8'd1);
    send(1, 8'h81);
    drop(1);
    wait_idle(1);
    tick();
    chk("t035_rises", rise4 - r0, 8);
    chk("t035_sck_high", hi4 - h0, 32);
    chk("t035_mosi", int'(mos4), 'h81);
    chk("t035_cs_low", cslow4 - c0, 68);

    // stall between bytes
    r0 = rise1;
    send(0, 8'd3);
    send(0, 8'hA5);
    drop(0);
    n = 0;
    while (!if1.tx_ready && n < 200) begin
      tick();
      n++;
    end
    chk("t036_reach_wait", int'(if1.tx_ready), 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (if1.cs_n !== 1'b0 || if1.sck !== 1'b0 ||
          if1.mosi !== 1'b1)
        bad++;
    end
    chk("t036_stall_bad", bad, 0);
    send(0, 8'h3C);
    send(0, 8'hC2);
    drop(0);
    wait_idle(0);
    tick();
    chk("t036_rises", rise1 - r0, 24);
    chk("t036_mosi", int'(mos1), 'h3CC2);

    // zero length discarded, next byte is a length
    send(0, 8'd0);
    send(0, 8'hAA);
    drop(0);
    repeat (3) tick();
    chk("t033_cs_n", int'(if1.cs_n), 1);
    chk("t033_sck", int'(if1.sck), 0);
    chk("t033_tx_ready", int'(if1.tx_ready), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // asynchronous reset mid-byte
    send(0, 8'd2);
    send(0, 8'hF0);
    drop(0);
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t037_cs_n", int'(if1.cs_n), 1);
    chk("t037_sck", int'(if1.sck), 0);
    chk("t037_tx_ready", int'(if1.tx_ready), 1);
    chk("t037_mosi", int'(if1.mosi), 0);
    #3 rst_n = 1'b1;
    tick();
    r0 = rise1;
    c0 = cslow1;
    send(0, 8'd1);
    send(0, 8'h3C);
    drop(0);
    wait_idle(0);
    tick();
    chk("t037_rises", rise1 - r0, 8);
    chk("t037_mosi", int'(mos1[7:0]), 'h3C);
    chk("t037_cs_low", cslow1 - c0, 17);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
